ntt_ct_butterfly_post: RTL and testbench
========================================

# ntt_ct_butterfly_post

Completes a Cooley–Tukey NTT butterfly downstream of the Montgomery reduction stage. The upstream control issues a twiddle·odd product into the multiplier/reduction pipeline and presents the matching even coefficient `u` to this block in the same cycle. This block time-aligns `u` with the reduced product `t` and brings `t` (< 2q) into [0, q). It outputs the butterfly pair (u + t) mod q and (u − t) mod q, fully pipelined at one item per cycle.

## Interface
Parameters:
- `W`, 32, coefficient / modulus width (matches reduction datapath).
- `LAT`, 6, cycles from issuing A/B to the reduction stage until its `res` for that item is valid; ≥ 1.
- `CW`, 16, width of the output item counter.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `q`  in  W  modulus, odd, q < 2^(W−1); sampled per item alongside `u_in`.
- `in_valid`  in  1  item issued this cycle (same cycle A/B enter reduction).
- `u_in`  in  W  even coefficient, required < q.
- `t_in`  in  W  reduction stage `res`; consumed LAT cycles after the matching `in_valid`; required < 2q.
- `out_valid`  out  1  butterfly result valid.
- `even_out`  out  W  (u + t) mod q.
- `odd_out`  out  W  (u − t) mod q.
- `range_err`  out  1  sticky: some valid item violated u < q or t < 2q.
- `out_count`  out  CW  number of results produced, wraps modulo 2^CW.

## Operation
- Delay line: `{in_valid, u_in, q}` pass through a LAT-deep shift register. At tap LAT they align with `t_in`. Only the valid bits are reset; the data bits are not.
- Stage C (registered): at the aligned tap, when the valid bit is set:
  - tc = (t ≥ q) ? t − q : t.
  - Register tc, u, q, valid.
  - Set `range_err` if t ≥ 2q or u ≥ q.
- Stage S (registered):
  - s = u + tc in W+1 bits; even = (s ≥ q) ? s − q : s.
  - d = u − tc in W+1 bits; odd = (d < 0) ? d + q : d.
  - Register `even_out`, `odd_out`, and `out_valid` from the stage-C valid.
- `out_count` increments by 1 in every cycle where stage S loads a valid item. 2^CW−1 wraps to 0.
- Outputs hold their last values when no valid item arrives; `out_valid` drops to 0.
- No backpressure. Reduction has no stall, so every issued item emerges exactly LAT+2 cycles later. A downstream consumer must accept every `out_valid` beat.
- Out-of-range inputs still produce outputs (value undefined but deterministic). `range_err` flags them.
- `range_err` clears only on `reset`.

## Timing
- Item issued with `in_valid` = 1 at cycle k:
  - `t_in` sampled at cycle k+LAT.
  - `out_valid` = 1 with the results at cycle k+LAT+2.
- `range_err` asserts at cycle k+LAT+1 for an offending item.
- Throughput: 1 item/cycle. Back-to-back items keep order, and no item is dropped or duplicated.
- Reset values, after the first clk with `reset` = 1:
  - `out_valid` = 0, `even_out` = 0, `odd_out` = 0, `range_err` = 0, `out_count` = 0.
  - All delay-line and stage valid bits = 0.
- Reset mid-operation: every in-flight item is discarded. `out_valid` stays 0 until an item issued after reset deassertion reaches the output.
- `reset` and `in_valid` in the same cycle: the item is discarded.

## Test plan
- q=3329, LAT=6; issue u=3000 at k; drive t=3500 at k+6 -> at k+8: out_valid=1, even=3171, odd=2829, range_err=0, out_count=1.
- q=3329; u=100, t=200 (no correction) -> even=300, odd=3229. Then u=3328, t=3328 -> even=3327, odd=0. Both boundaries are hit.
- Stream 64 back-to-back random items (u<q, t<2q), q=3329 and q=12289 interleaved per item -> every output matches the reference model in order at LAT+2; out_count=64; no gaps.
- q=3329; one item with t=6658 (=2q) -> range_err=1 at k+7 and remains 1 through later valid items; out_count still increments.
- Issue 4 items, assert reset for one cycle at k+3 -> no out_valid for any of them. An item issued at k+5 appears at k+5+LAT+2 with out_count=1.
- Preload out_count to 2^CW−1 by streaming 65535 items (CW=16) -> the next valid result yields out_count=0.

Source files
------------

// File: rtl/ntt_ct_butterfly_post_if.sv
// Bus bundle for the post-reduction NTT butterfly: issue-side inputs plus
// the butterfly result, error flag and item counter.
interface ntt_ct_butterfly_post_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    // No backpressure: in_valid marks an issued item, and out_valid marks a
    // result beat that the consumer must take in that same cycle.
    logic          in_valid;
    logic [W-1:0]  q;
    logic [W-1:0]  u_in;
    logic [W-1:0]  t_in;
    logic          out_valid;
    logic [W-1:0]  even_out;
    logic [W-1:0]  odd_out;
    logic          range_err;
    logic [CW-1:0] out_count;

    modport master (
        output in_valid, q, u_in, t_in,
        input  out_valid, even_out, odd_out, range_err, out_count
    );

    modport slave (
        input  in_valid, q, u_in, t_in,
        output out_valid, even_out, odd_out, range_err, out_count
    );
endinterface

// File: rtl/ntt_ct_butterfly_post.sv
// Cooley-Tukey butterfly tail: aligns u with the reduced product t, brings
// t below q, and emits (u + t) mod q and (u - t) mod q at one item per cycle.
module ntt_ct_butterfly_post #(
    parameter int W   = 32,
    parameter int LAT = 6,
    parameter int CW  = 16
) (
    input logic                  clk,
    input logic                  reset,
    ntt_ct_butterfly_post_if.slave bus
);

    // Delay line; index LAT-1 is the tap aligned with t_in.
    logic [LAT-1:0] v_dly;
    logic [W-1:0]   u_dly [LAT];
    logic [W-1:0]   q_dly [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            v_dly <= '0;
        end else begin
            v_dly[0] <= bus.in_valid;
            for (int i = 1; i < LAT; i++) begin
                v_dly[i] <= v_dly[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        u_dly[0] <= bus.u_in;
        q_dly[0] <= bus.q;
        for (int i = 1; i < LAT; i++) begin
            u_dly[i] <= u_dly[i-1];
            q_dly[i] <= q_dly[i-1];
        end
    end

    logic         a_v;
    logic [W-1:0] a_u;
    logic [W-1:0] a_q;
    logic [W-1:0] a_t;

    assign a_v = v_dly[LAT-1];
    assign a_u = u_dly[LAT-1];
    assign a_q = q_dly[LAT-1];
    assign a_t = bus.t_in;

    logic [W:0]   q_x2;
    logic         t_ge_q;
    logic         t_ge_2q;
    logic         u_ge_q;
    logic [W-1:0] tc_n;

    always_comb begin
        q_x2    = {a_q, 1'b0};
        t_ge_q  = (a_t >= a_q);
        t_ge_2q = ({1'b0, a_t} >= q_x2);
        u_ge_q  = (a_u >= a_q);
        tc_n    = t_ge_q ? (a_t - a_q) : a_t;
    end

    logic         c_v;
    logic [W-1:0] c_tc;
    logic [W-1:0] c_u;
    logic [W-1:0] c_q;
    logic         err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_v   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            c_v <= a_v;
            if (a_v && (t_ge_2q || u_ge_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_v) begin
            c_tc <= tc_n;
            c_u  <= a_u;
            c_q  <= a_q;
        end
    end

    // Sum and difference are one bit wider so the carry/borrow picks the fix-up.
    logic [W:0]   s_full;
    logic [W:0]   d_full;
    logic [W-1:0] s_red;
    logic [W-1:0] d_fix;
    logic [W-1:0] even_n;
    logic [W-1:0] odd_n;

    always_comb begin
        s_full = {1'b0, c_u} + {1'b0, c_tc};
        d_full = {1'b0, c_u} - {1'b0, c_tc};
        s_red  = s_full[W-1:0] - c_q;
        d_fix  = d_full[W-1:0] + c_q;
        even_n = (s_full >= {1'b0, c_q}) ? s_red : s_full[W-1:0];
        odd_n  = d_full[W] ? d_fix : d_full[W-1:0];
    end

    logic          ov_q;
    logic [W-1:0]  even_q;
    logic [W-1:0]  odd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ov_q   <= 1'b0;
            even_q <= '0;
            odd_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ov_q <= c_v;
            if (c_v) begin
                even_q <= even_n;
                odd_q  <= odd_n;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.even_out  = even_q;
    assign bus.odd_out   = odd_q;
    assign bus.range_err = err_q;
    assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_ntt_ct_butterfly_post.sv
// Scoreboard bench for ntt_ct_butterfly_post: drivers push expected results
// at issue time, a monitor pops and compares on every out_valid beat.
module tb_ntt_ct_butterfly_post;
    localparam int W   = 32;
    localparam int LAT = 6;
    localparam int CW  = 16;
    localparam int EW  = 1 + 32 + 2 * W + CW;
    localparam int ND  = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt_ct_butterfly_post_if #(.W(W), .CW(CW)) bus ();

    ntt_ct_butterfly_post #(.W(W), .LAT(LAT), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;
    logic [W-1:0]  t_hist [LAT+1];

    // Hand-computed vectors: q, u, t, expected even, expected odd.
    logic [W-1:0] dv_q [ND] = '{3329, 3329, 3329, 3329, 3329, 3329, 12289, 12289, 12289};
    logic [W-1:0] dv_u [ND] = '{3000, 100,  3328, 0,    0,    5,    12288, 1,     0};
    logic [W-1:0] dv_t [ND] = '{3500, 200,  3328, 0,    3329, 6657, 24577, 12290, 1};
    logic [W-1:0] dv_e [ND] = '{3171, 300,  3327, 0,    0,    4,    12287, 2,     1};
    logic [W-1:0] dv_o [ND] = '{2829, 3229, 0,    0,    0,    6,    0,     0,     12288};

    function automatic logic [2*W-1:0] model(input logic [W-1:0] u, input logic [W-1:0] t,
                                             input logic [W-1:0] qq);
        longint unsigned tc, e, o;
        tc = longint'(t) % longint'(qq);
        e  = (longint'(u) + tc) % longint'(qq);
        o  = (longint'(u) + longint'(qq) - tc) % longint'(qq);
        return {e[W-1:0], o[W-1:0]};
    endfunction

    // One cycle of drive; t_in follows the item issued LAT cycles earlier.
    task automatic step(input bit v, input logic [W-1:0] u, input logic [W-1:0] t,
                        input logic [W-1:0] qq, input bit rst, input bit push,
                        input bit chk, input logic [2*W-1:0] r);
        @(negedge clk);
        for (int i = LAT; i > 0; i--) t_hist[i] = t_hist[i-1];
        t_hist[0]    = t;
        reset        = rst;
        bus.in_valid = v;
        bus.u_in     = u;
        bus.q        = qq;
        bus.t_in     = t_hist[LAT];
        if (rst) exp_cnt = '0;
        if (v && push && !rst) begin
            exp_cnt = exp_cnt + 1'b1;
            exp_q.push_back({chk, 32'(cyc + LAT + 2), r, exp_cnt});
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic issue(input logic [W-1:0] u, input logic [W-1:0] t, input logic [W-1:0] qq);
        step(1'b1, u, t, qq, 1'b0, 1'b1, 1'b1, model(u, t, qq));
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 12 && exp_q.size() != 0; i++) idle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every out_valid beat must match the oldest expected entry.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got out_valid=1 at cycle %0d expected none", cyc);
            end else begin
                logic [EW-1:0] ent;
                logic          e_chk;
                logic [31:0]   e_due;
                logic [W-1:0]  e_even, e_odd;
                logic [CW-1:0] e_cnt;
                ent = exp_q.pop_front();
                {e_chk, e_due, e_even, e_odd, e_cnt} = ent;
                n_cmp++;
                if (cyc !== e_due) begin
                    n_bad++;
                    $display("FAIL latency: got cycle %0d expected %0d", cyc, e_due);
                end
                n_cmp++;
                if (bus.out_count !== e_cnt) begin
                    n_bad++;
                    $display("FAIL out_count: got %0d expected %0d", bus.out_count, e_cnt);
                end
                if (e_chk) begin
                    n_cmp++;
                    if (bus.even_out !== e_even || bus.odd_out !== e_odd) begin
                        n_bad++;
                        $display("FAIL butterfly: got even=%0d odd=%0d expected even=%0d odd=%0d",
                                 bus.even_out, bus.odd_out, e_even, e_odd);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] qq, u, t;
        int           n;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.u_in     = '0;
        bus.t_in     = '0;
        bus.q        = '0;
        exp_cnt      = '0;
        for (int i = 0; i <= LAT; i++) t_hist[i] = '0;

        // Reset, with an item coinciding with reset that must be discarded.
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 32'd7, 32'd9, 32'd3329, 1'b1, 1'b0, 1'b0, '0);
        idle();
        check("rst_out_valid", {31'd0, bus.out_valid}, '0);
        check("rst_even", bus.even_out, '0);
        check("rst_odd", bus.odd_out, '0);
        check("rst_range_err", {31'd0, bus.range_err}, '0);
        check("rst_out_count", {16'd0, bus.out_count}, '0);

        // Directed vectors, back to back.
        for (int i = 0; i < ND; i++)
            step(1'b1, dv_u[i], dv_t[i], dv_q[i], 1'b0, 1'b1, 1'b1, {dv_e[i], dv_o[i]});
        drain();
        check("count_directed", {16'd0, bus.out_count}, ND);
        check("range_err_clean", {31'd0, bus.range_err}, '0);

        // 64 random in-range items, q alternating per item.
        for (int i = 0; i < 64; i++) begin
            qq = (i % 2 == 0) ? 32'd3329 : 32'd12289;
            u  = $urandom_range(0, qq - 1);
            t  = $urandom_range(0, 2 * qq - 1);
            issue(u, t, qq);
        end
        drain();
        check("count_stream", {16'd0, bus.out_count}, ND + 64);
        check("range_err_stream", {31'd0, bus.range_err}, '0);

        // t = 2q: flagged one cycle after the aligned tap and stays sticky.
        step(1'b1, 32'd10, 32'd6658, 32'd3329, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < LAT; i++) idle();
        check("range_err_kplus6", {31'd0, bus.range_err}, '0);
        idle();
        check("range_err_kplus7", {31'd0, bus.range_err}, 32'd1);
        issue(32'd100, 32'd200, 32'd3329);
        issue(32'd3328, 32'd3328, 32'd3329);
        drain();
        check("range_err_sticky", {31'd0, bus.range_err}, 32'd1);
        check("count_after_err", {16'd0, bus.out_count}, ND + 64 + 3);

        // Reset in flight: four items lost, later item counts from 1.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'd50 + i, 32'd60 + i, 32'd3329, (i == 3), 1'b0, 1'b0, '0);
        idle();
        check("range_err_cleared", {31'd0, bus.range_err}, '0);
        step(1'b1, 32'd100, 32'd200, 32'd3329, 1'b0, 1'b1, 1'b1, {32'd300, 32'd3229});
        drain();
        check("count_after_reset", {16'd0, bus.out_count}, 32'd1);

        // Counter wrap: fill to 2^CW-1, then one more result wraps to 0.
        n = 65535 - int'(exp_cnt);
        for (int i = 0; i < n; i++) begin
            u = i % 3329;
            t = (i * 7) % 6658;
            issue(u, t, 32'd3329);
        end
        drain();
        check("count_full", {16'd0, bus.out_count}, 32'd65535);
        issue(32'd1234, 32'd4000, 32'd3329);
        drain();
        check("count_wrap", {16'd0, bus.out_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
